// File: rtl/i2c_pkg.sv
// Shared constants for the I2C bus front end: filter counter width and
// default filter / timeout lengths.
package i2c_pkg;

    localparam int FILT_CNT_W         = 4;
    localparam int FILT_LEN_DEF       = 4;
    localparam int TIMEOUT_CYCLES_DEF = 25000;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: two-flop synchroniser, persistence glitch filter and
// combinational edge detect on the filtered level.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_filt,
    output logic o_rise_c,
    output logic o_fall_c
);

    localparam logic [FILT_CNT_W-1:0] C_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_filt;
    logic                  r_filt_d;
    logic [FILT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_pin;
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            // A new level must persist FILT_LEN consecutive samples to be accepted.
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt   = r_filt;
    assign o_rise_c = r_filt & ~r_filt_d;
    assign o_fall_c = ~r_filt & r_filt_d;

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C input conditioning: filtered SCL/SDA, SCL edge / START / STOP strobes
// and bus-busy tracking. Define I2C_TIMEOUT_EN to add the SCL-low bus timeout.
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter int FILT_LEN       = FILT_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    input  logic sda_oe,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout
);

    if (FILT_LEN < 1 || FILT_LEN > (2 ** FILT_CNT_W) - 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("i2c_bus_frontend: FILT_LEN must be 1..15 and TIMEOUT_CYCLES at least 2");
    end

    logic w_scl_rise_c;
    logic w_scl_fall_c;
    logic w_sda_rise_c;
    logic w_sda_fall_c;
    logic w_scl_quiet_hi;
    logic w_start_c;
    logic w_stop_c;
    logic w_tmo_hit;

    logic r_scl_rise;
    logic r_scl_fall;
    logic r_start;
    logic r_stop;
    logic r_busy;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clock    (clock),
        .reset    (reset),
        .i_pin    (scl_in),
        .o_filt   (scl_f),
        .o_rise_c (w_scl_rise_c),
        .o_fall_c (w_scl_fall_c)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clock    (clock),
        .reset    (reset),
        .i_pin    (sda_in),
        .o_filt   (sda_f),
        .o_rise_c (w_sda_rise_c),
        .o_fall_c (w_sda_fall_c)
    );

    // SCL high and not having just risen: a simultaneous SCL/SDA change is a data glitch.
    assign w_scl_quiet_hi = scl_f & ~w_scl_rise_c;
    assign w_start_c      = w_sda_fall_c & w_scl_quiet_hi & ~sda_oe;
    assign w_stop_c       = w_sda_rise_c & w_scl_quiet_hi & ~sda_oe;

`ifdef I2C_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_tmo;

    assign w_tmo_hit = ~scl_f & r_busy & (r_to_cnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_tmo    <= 1'b0;
        end else begin
            r_tmo <= w_tmo_hit;
            if (~scl_f & r_busy & ~w_tmo_hit) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign timeout = r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_rise <= w_scl_rise_c;
            r_scl_fall <= w_scl_fall_c;
            r_start    <= w_start_c;
            r_stop     <= w_stop_c;
            if (w_start_c) begin
                r_busy <= 1'b1;
            end else if (w_stop_c | w_tmo_hit) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign bus_busy  = r_busy;

endmodule
